// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-road phase sequencer with shared countdown, demand routing and all-red override
module traffic_phase_scheduler #(
  parameter int TICK_DIV = 50_000_000,
  parameter int T_GO     = 27,
  parameter int T_LT     = 17,
  parameter int T_Y      = 3
) (
  input  logic       clk_50M,
  input  logic       reset_btn,
  input  logic [1:0] AS,
  input  logic [1:0] BS,
  input  logic       emergency,
  output logic       AG,
  output logic       AGL,
  output logic       AY,
  output logic       AR,
  output logic       BG,
  output logic       BGL,
  output logic       BY,
  output logic       BR,
  output logic [3:0] phase,
  output logic [7:0] phase_cnt,
  output logic       tick
);

  typedef enum logic [3:0] {
    A_GO    = 4'd0,
    A_Y     = 4'd1,
    A_LT    = 4'd2,
    A_LY    = 4'd3,
    B_GO    = 4'd4,
    B_Y     = 4'd5,
    B_LT    = 4'd6,
    B_LY    = 4'd7,
    ALL_RED = 4'd8
  } phase_e;

  localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       D_GO     = 8'(T_GO);
  localparam logic [7:0]       D_LT     = 8'(T_LT);
  localparam logic [7:0]       D_Y      = 8'(T_Y);

  // Lamp vector order: {AG, AGL, AY, AR, BG, BGL, BY, BR}
  function automatic logic [7:0] lamp_of(input phase_e s);
    case (s)
      A_GO:       lamp_of = 8'b1000_0001;
      A_LT:       lamp_of = 8'b0100_0001;
      A_Y, A_LY:  lamp_of = 8'b0010_0001;
      B_GO:       lamp_of = 8'b0001_1000;
      B_LT:       lamp_of = 8'b0001_0100;
      B_Y, B_LY:  lamp_of = 8'b0001_0010;
      default:    lamp_of = 8'b0001_0001;
    endcase
  endfunction

  // Seconds loaded into the countdown when a phase is entered
  function automatic logic [7:0] dur_of(input phase_e s);
    case (s)
      A_GO, B_GO:             dur_of = D_GO;
      A_LT, B_LT:             dur_of = D_LT;
      A_Y, A_LY, B_Y, B_LY:   dur_of = D_Y;
      default:                dur_of = 8'd0;
    endcase
  endfunction

  // Successor of a phase; only consulted when a transition is due.
  // Yellow phases divert to ALL_RED if emergency is present at expiry.
  function automatic phase_e next_of(input phase_e s, input logic emg,
                                     input logic da, input logic db);
    case (s)
      A_GO:    next_of = A_Y;
      A_Y:     next_of = emg ? ALL_RED : A_LT;
      A_LT:    next_of = A_LY;
      A_LY:    next_of = emg ? ALL_RED : (db ? B_GO : A_GO);
      B_GO:    next_of = B_Y;
      B_Y:     next_of = emg ? ALL_RED : B_LT;
      B_LT:    next_of = B_LY;
      B_LY:    next_of = emg ? ALL_RED : ((da || !db) ? A_GO : B_GO);
      default: next_of = A_GO;
    endcase
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [1:0]       as_meta;
  logic [1:0]       as_sync;
  logic [1:0]       bs_meta;
  logic [1:0]       bs_sync;
  logic             emg_meta;
  logic             emg_s;
  logic             dem_a;
  logic             dem_b;
  phase_e           state;
  phase_e           state_nxt;
  logic [7:0]       lamps;
  logic             expire;
  logic             is_run;
  logic             load_en;
  logic             enter_a_go;
  logic             enter_b_go;

  assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);

  // Free-running 1-second divider; the strobe is registered so it is high while the count sits at its last value
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      tick    <= (div_nxt == DIV_LAST);
    end
  end

  // Two-flop synchronisers for the asynchronous sensors and emergency request
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      as_meta  <= 2'b00;
      as_sync  <= 2'b00;
      bs_meta  <= 2'b00;
      bs_sync  <= 2'b00;
      emg_meta <= 1'b0;
      emg_s    <= 1'b0;
    end else begin
      as_meta  <= AS;
      as_sync  <= as_meta;
      bs_meta  <= BS;
      bs_sync  <= bs_meta;
      emg_meta <= emergency;
      emg_s    <= emg_meta;
    end
  end

  assign expire     = tick && (phase_cnt == 8'd1);
  assign is_run     = (state == A_GO) || (state == A_LT) || (state == B_GO) || (state == B_LT);
  assign load_en    = (state == ALL_RED) ? !emg_s : (expire || (is_run && emg_s));
  assign state_nxt  = next_of(state, emg_s, dem_a, dem_b);
  assign enter_a_go = load_en && (state_nxt == A_GO);
  assign enter_b_go = load_en && (state_nxt == B_GO);

  // Latched demand: served road's flag clears on entry to its GO, but a live sensor keeps it set
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      dem_a <= 1'b0;
      dem_b <= 1'b0;
    end else begin
      dem_a <= (|as_sync) || (dem_a && !enter_a_go);
      dem_b <= (|bs_sync) || (dem_b && !enter_b_go);
    end
  end

  // Phase FSM: state, countdown and lamps all change on the same edge
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      state     <= A_GO;
      phase_cnt <= D_GO;
      lamps     <= lamp_of(A_GO);
    end else if (load_en) begin
      state     <= state_nxt;
      phase_cnt <= dur_of(state_nxt);
      lamps     <= lamp_of(state_nxt);
    end else if (tick && (state != ALL_RED)) begin
      phase_cnt <= phase_cnt - 8'd1;
    end
  end

  assign phase = state;
  assign {AG, AGL, AY, AR, BG, BGL, BY, BR} = lamps;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed self-checking bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

  logic       clk_50M;
  logic       reset_btn;
  logic [1:0] AS;
  logic [1:0] BS;
  logic       emergency;
  logic       AG, AGL, AY, AR, BG, BGL, BY, BR;
  logic [3:0] phase;
  logic [7:0] phase_cnt;
  logic       tick;
  logic [7:0] lamps;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] L_AGO  = 8'b1000_0001;
  localparam logic [7:0] L_AY   = 8'b0010_0001;
  localparam logic [7:0] L_ALT  = 8'b0100_0001;
  localparam logic [7:0] L_BGO  = 8'b0001_1000;
  localparam logic [7:0] L_BLT  = 8'b0001_0100;
  localparam logic [7:0] L_RED  = 8'b0001_0001;

  assign lamps = {AG, AGL, AY, AR, BG, BGL, BY, BR};

  traffic_phase_scheduler #(
    .TICK_DIV(4),
    .T_GO(27),
    .T_LT(17),
    .T_Y(3)
  ) dut (
    .clk_50M(clk_50M),
    .reset_btn(reset_btn),
    .AS(AS),
    .BS(BS),
    .emergency(emergency),
    .AG(AG),
    .AGL(AGL),
    .AY(AY),
    .AR(AR),
    .BG(BG),
    .BGL(BGL),
    .BY(BY),
    .BR(BR),
    .phase(phase),
    .phase_cnt(phase_cnt),
    .tick(tick)
  );

  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] ph, input logic [7:0] cnt);
    check({tag, "_phase"}, 32'(phase), 32'(ph));
    check({tag, "_cnt"}, 32'(phase_cnt), 32'(cnt));
  endtask

  initial begin
    reset_btn = 1'b1;
    AS        = 2'b00;
    BS        = 2'b00;
    emergency = 1'b0;

    // E0: reset edge
    cyc(1);
    reset_btn = 1'b0;
    check_state("reset", 4'd0, 8'd27);
    check("reset_lamps", 32'(lamps), 32'(L_AGO));
    check("reset_tick", 32'(tick), 32'd0);

    // First tick visible after E3, consumed at E4
    cyc(3);
    check("first_tick", 32'(tick), 32'd1);
    check("first_tick_cnt", 32'(phase_cnt), 32'd27);
    cyc(1);
    check("tick_drop", 32'(tick), 32'd0);
    check("first_dec", 32'(phase_cnt), 32'd26);

    // E107 last second of A_GO, E108 into A_Y
    cyc(103);
    check_state("ago_end", 4'd0, 8'd1);
    cyc(1);
    check_state("ay_entry", 4'd1, 8'd3);
    check("ay_lamps", 32'(lamps), 32'(L_AY));

    // E200 idle: back to A_GO
    cyc(92);
    check_state("idle_wrap", 4'd0, 8'd27);
    check("idle_wrap_lamps", 32'(lamps), 32'(L_AGO));

    // One-cycle side-road pulse during A_GO
    BS = 2'b01;
    cyc(1);
    BS = 2'b00;
    cyc(198);
    check_state("aly_end", 4'd3, 8'd1);
    cyc(1);
    check_state("bgo_entry", 4'd4, 8'd27);
    check("bgo_lamps", 32'(lamps), 32'(L_BGO));
    cyc(120);
    check_state("blt_entry", 4'd6, 8'd17);
    check("blt_lamps", 32'(lamps), 32'(L_BLT));
    cyc(80);
    check_state("b_return_a", 4'd0, 8'd27);

    // Emergency at A_LT with 10 seconds left (E748)
    cyc(148);
    check_state("alt_cnt10", 4'd2, 8'd10);
    check("alt_lamps", 32'(lamps), 32'(L_ALT));
    emergency = 1'b1;
    cyc(2);
    check_state("emg_lat2", 4'd2, 8'd10);
    cyc(1);
    check_state("emg_aly", 4'd3, 8'd3);
    check("emg_aly_lamps", 32'(lamps), 32'(L_AY));
    cyc(8);
    check_state("emg_aly_end", 4'd3, 8'd1);
    cyc(1);
    check_state("allred_entry", 4'd8, 8'd0);
    check("allred_lamps", 32'(lamps), 32'(L_RED));
    cyc(80);
    check_state("allred_hold", 4'd8, 8'd0);
    check("allred_hold_lamps", 32'(lamps), 32'(L_RED));
    emergency = 1'b0;
    cyc(2);
    check_state("release_lat2", 4'd8, 8'd0);
    cyc(1);
    check_state("release_ago", 4'd0, 8'd27);
    check("release_lamps", 32'(lamps), 32'(L_AGO));

    // BS held through B_GO entry, dropped so the synced level falls right after entry
    BS = 2'b01;
    cyc(195);
    BS = 2'b00;
    cyc(1);
    check_state("hold_aly_end", 4'd3, 8'd1);
    cyc(1);
    check_state("hold_bgo", 4'd4, 8'd27);
    check("hold_bgo_lamps", 32'(lamps), 32'(L_BGO));
    cyc(199);
    check_state("hold_bly_end", 4'd7, 8'd1);
    cyc(1);
    check_state("b_repeat", 4'd4, 8'd27);

    // Reset during B_LT with 5 seconds left (E1408)
    cyc(168);
    check_state("blt_cnt5", 4'd6, 8'd5);
    reset_btn = 1'b1;
    cyc(1);
    reset_btn = 1'b0;
    check_state("midreset", 4'd0, 8'd27);
    check("midreset_lamps", 32'(lamps), 32'(L_AGO));
    check("midreset_tick", 32'(tick), 32'd0);
    cyc(2);
    check("midreset_notick", 32'(tick), 32'd0);
    cyc(1);
    check("midreset_tick4", 32'(tick), 32'd1);
    cyc(1);
    check_state("midreset_dec", 4'd0, 8'd26);

    // Both roads demanding: alternate every 50 ticks
    AS = 2'b01;
    BS = 2'b01;
    cyc(196);
    check_state("alt_b1", 4'd4, 8'd27);
    cyc(200);
    check_state("alt_a2", 4'd0, 8'd27);
    cyc(200);
    check_state("alt_b2", 4'd4, 8'd27);
    check("alt_b2_lamps", 32'(lamps), 32'(L_BGO));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Sensor-driven phase sequencer for the two-road intersection controller. It owns a single shared 1-second countdown and steps both roads through go / yellow / left-turn / yellow phases. It decides at each cycle boundary which road gets the next cycle, based on latched vehicle demand. It also enforces an emergency all-red override. It sits between the synchronised sensor inputs (AS*/BS*) and the lamp drivers / LCD countdown formatter in the traffic-light top level.

## Interface
- TICK_DIV, 50_000_000: clk_50M cycles per 1-second tick (bench uses 4).
- T_GO, 27: straight-green duration, seconds.
- T_LT, 17: left-turn-green duration, seconds.
- T_Y, 3: yellow duration, seconds.
- clk_50M  in  1  system clock; one clock domain.
- reset_btn  in  1  synchronous, active-high reset.
- AS  in  2  main-road vehicle sensors {AS2,AS1}, asynchronous.
- BS  in  2  side-road vehicle sensors {BS2,BS1}, asynchronous.
- emergency  in  1  all-red request, asynchronous, level.
- AG, AGL, AY, AR  out  1 each  main-road green / left-green / yellow / red.
- BG, BGL, BY, BR  out  1 each  side-road equivalents.
- phase  out  4  current state encoding (below).
- phase_cnt  out  8  seconds remaining in current phase; 0 only in ALL_RED.
- tick  out  1  one-cycle 1-second strobe.

## Operation
- States (encoding): A_GO=0, A_Y=1, A_LT=2, A_LY=3, B_GO=4, B_Y=5, B_LT=6, B_LY=7, ALL_RED=8.
- Lamps, exactly one lit per road, registered from the state:
  - A_GO: AG + BR.
  - A_LT: AGL + BR.
  - A_Y / A_LY: AY + BR.
  - B_GO: BG + AR.
  - B_LT: BGL + AR.
  - B_Y / B_LY: BY + AR.
  - ALL_RED: AR + BR.
- Duration loaded into phase_cnt on entry:
  - GO: T_GO.
  - LT: T_LT.
  - Y / LY: T_Y.
  - ALL_RED: 0.
- Sequence within a road: GO → Y → LT → LY.
- Countdown: phase_cnt decrements on tick. Expiry is tick while phase_cnt==1. On expiry the next state and its duration load on the same edge, so a phase lasts exactly its duration in ticks.
- Demand registers dem_a, dem_b:
  - Sensors pass through a 2-FF synchroniser, then OR-reduce.
  - dem_x sets while the synced sensor is high.
  - dem_x clears on entry to X_GO. Set wins over clear.
- Routing:
  - At A_LY expiry: go to B_GO if dem_b, else A_GO.
  - At B_LY expiry: go to A_GO if dem_a or !dem_b, else B_GO.
  - Idle (no demand) therefore rests on road A.
- Emergency (2-FF synchronised, emg_s):
  - In any GO or LT phase: jump next cycle to that road's Y/LY respectively, loading T_Y.
  - In Y/LY: the phase runs to expiry, then enters ALL_RED instead of its normal successor.
  - In ALL_RED: held while emg_s=1.
  - The first cycle with emg_s=0 in ALL_RED enters A_GO with T_GO. Demand is preserved.
- Tick divider:
  - Free-running counter 0..TICK_DIV-1; tick=1 when it equals TICK_DIV-1.
  - Cleared only by reset, never by phase changes.

## Timing
- Reset (synchronous, evaluated at clk_50M edge with reset_btn=1):
  - State A_GO, phase_cnt=T_GO.
  - AG=1, BR=1, all other lamps 0.
  - tick=0, divider=0, dem_a=dem_b=0, synchronisers=0.
- Reset mid-phase behaves identically, with no partial countdown retained.
- All outputs are registered. Lamps and phase change on the same edge that loads phase_cnt.
- First tick after reset: TICK_DIV cycles after reset release.
- Sensor-to-demand latency: 3 cycles. A pulse of ≥1 cycle that meets setup is captured.
- Emergency-to-yellow latency from a GO/LT phase: 3 cycles.
- Full normal cycle per road: 2·T_Y+T_GO+T_LT = 50 ticks.
- Expiry coinciding with emergency assertion in GO/LT: the transition is to Y/LY either way, with T_Y loaded.
- Expiry coinciding with emergency release in ALL_RED: not applicable (no countdown in ALL_RED).
- phase_cnt is 8 bits. Durations must be 1..255; 0 is illegal and is not checked.

## Test plan
- Reset with TICK_DIV=4 and no sensors: AG=1, BR=1, phase=0, phase_cnt=27. After 108 cycles: phase=1, AY=1, cnt=3. After 200 cycles: back at phase=0, cnt=27.
- 1-cycle BS pulse during A_GO, AS=0: after A_LY expiry, phase=4, BG=1, AR=1, cnt=27. With no further demand, after B_LY the sequence returns to A_GO.
- AS=BS=01 held constant: phases alternate A,B with a 50-tick period each. dem_a and dem_b never both remain 0.
- emergency raised at A_LT with cnt=10: 3 cycles later phase=3, AY=1, cnt=3. After 3 ticks: phase=8, AR=BR=1, cnt=0. Held 20 ticks unchanged. On release: A_GO, cnt=27.
- reset_btn pulsed during B_LT with cnt=5: next edge gives phase=0, AG=1, BR=1, cnt=27, and the first tick arrives exactly 4 cycles after release.
- BS held high while entering B_GO: dem_b reads 1 the cycle after entry (set beats clear), so B repeats at B_LY when AS=0.
